vdb_vga_timing_ctrl: RTL and testbench

//  VESA-style VGA timing controller/sequencer driving the vdb VGA monitor model.

---
 rtl/vdb_vga_timing_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_vdb_vga_timing_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdb_vga_timing_ctrl.sv
// -----------------------------------------------------------------------------
// vdb_vga_timing_ctrl
//   VESA-style VGA timing controller. Two FSMs walk each line and frame
//   through SYNC -> BP -> ACT -> FP. Pixels are fetched from a frame source
//   through a fixed-latency request port, and the result is emitted as r/g/b
//   together with active-low hsync/vsync. Porch and sync widths can be changed
//   at runtime. Writes land in shadow registers and take effect at the next
//   frame boundary.
//
// Ports
//   pixel_clk            pixel clock (only clock)
//   rst                  synchronous, active-high reset
//   cfg_we/cfg_sel       write cfg_fp/cfg_sync/cfg_bp into the horizontal (0)
//                        or vertical (1) shadow
//   cfg_pending          a shadow was written but not yet applied
//   pix_req/pix_x/pix_y  stage-0 pixel fetch request with active coordinates
//   pix_r/pix_g/pix_b    pixel data, valid exactly one cycle after pix_req
//   r/g/b                video out (stage 2), zero outside active video
//   hsync/vsync          active-low syncs (stage 2)
//   frame_start          one-cycle pulse on the first cycle of a frame (stage 2)
//   h_state_dbg          line FSM state (H_SYNC=0, H_BP=1, H_ACT=2, H_FP=3)
//   v_state_dbg          frame FSM state (V_SYNC=0, V_BP=1, V_ACT=2, V_FP=3)
//
// Fetch protocol: the port has no back-pressure. When pix_req is high in
// cycle t, the source must present pix_r/g/b for (pix_x, pix_y) during
// cycle t+1. That data is registered onto r/g/b and appears in cycle t+2.
// -----------------------------------------------------------------------------
module vdb_vga_timing_ctrl #(
  parameter int HOR_ACT   = 640,
  parameter int HOR_FP    = 16,
  parameter int HOR_SYNC  = 96,
  parameter int HOR_BP    = 48,
  parameter int VERT_ACT  = 480,
  parameter int VERT_FP   = 11,
  parameter int VERT_SYNC = 2,
  parameter int VERT_BP   = 31
) (
  input  logic       pixel_clk,
  input  logic       rst,
  input  logic       cfg_we,
  input  logic       cfg_sel,
  input  logic [7:0] cfg_fp,
  input  logic [7:0] cfg_sync,
  input  logic [7:0] cfg_bp,
  output logic       cfg_pending,
  output logic       pix_req,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  input  logic [7:0] pix_r,
  input  logic [7:0] pix_g,
  input  logic [7:0] pix_b,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic [1:0] h_state_dbg,
  output logic [1:0] v_state_dbg
);

  typedef enum logic [1:0] {H_SYNC = 2'd0, H_BP = 2'd1, H_ACT = 2'd2, H_FP = 2'd3} h_state_t;
  typedef enum logic [1:0] {V_SYNC = 2'd0, V_BP = 2'd1, V_ACT = 2'd2, V_FP = 2'd3} v_state_t;

  localparam logic [10:0] H_ACT_LAST   = 11'(HOR_ACT - 1);
  localparam logic [10:0] V_ACT_LAST   = 11'(VERT_ACT - 1);
  localparam logic [9:0]  H_ACT_LAST10 = 10'(HOR_ACT - 1);
  localparam logic [9:0]  V_ACT_LAST10 = 10'(VERT_ACT - 1);

  // Shadow (written by cfg) and live (used by the FSMs) timing.
  logic [7:0] sh_hfp, sh_hsync, sh_hbp, sh_vfp, sh_vsync, sh_vbp;
  logic [7:0] lv_hfp, lv_hsync, lv_hbp, lv_vfp, lv_vsync, lv_vbp;
  logic       pending_q;

  // sof_q marks the first stage-0 cycle of a frame (H_SYNC, V_SYNC, line 0).
  logic       sof_q;

  h_state_t   h_state, h_state_nx;
  v_state_t   v_state, v_state_nx;
  logic [10:0] h_cnt, h_cnt_nx, h_cnt_cur;
  logic [10:0] v_cnt, v_cnt_nx, v_cnt_cur;
  logic        line_end, frame_end;

  // Effective timing for this cycle. On the apply cycle, the shadow values
  // are already in force, so line 0 of the new frame uses them immediately.
  logic [7:0]  e_hfp, e_hbp, e_vfp, e_vbp, e_hsync, e_vsync;
  logic [10:0] h_sync_len, v_sync_len;

  always_comb begin
    e_hfp   = sof_q ? sh_hfp   : lv_hfp;
    e_hsync = sof_q ? sh_hsync : lv_hsync;
    e_hbp   = sof_q ? sh_hbp   : lv_hbp;
    e_vfp   = sof_q ? sh_vfp   : lv_vfp;
    e_vsync = sof_q ? sh_vsync : lv_vsync;
    e_vbp   = sof_q ? sh_vbp   : lv_vbp;
    // A zero sync width is treated as one.
    h_sync_len = (e_hsync == 8'd0) ? 11'd1 : {3'b000, e_hsync};
    v_sync_len = (e_vsync == 8'd0) ? 11'd1 : {3'b000, e_vsync};
  end

  // Line FSM: the counter holds the remaining cycles in the state minus one.
  // On the first cycle of a frame, the count comes from the newly applied sync
  // width instead of whatever was loaded at the end of the previous frame.
  always_comb begin
    h_cnt_cur  = sof_q ? (h_sync_len - 11'd1) : h_cnt;
    h_state_nx = h_state;
    h_cnt_nx   = h_cnt_cur - 11'd1;
    line_end   = 1'b0;
    if (h_cnt_cur == 11'd0) begin
      case (h_state)
        H_SYNC: begin
          if (e_hbp != 8'd0) begin
            h_state_nx = H_BP;
            h_cnt_nx   = {3'b000, e_hbp} - 11'd1;
          end else begin
            h_state_nx = H_ACT;
            h_cnt_nx   = H_ACT_LAST;
          end
        end
        H_BP: begin
          h_state_nx = H_ACT;
          h_cnt_nx   = H_ACT_LAST;
        end
        H_ACT: begin
          if (e_hfp != 8'd0) begin
            h_state_nx = H_FP;
            h_cnt_nx   = {3'b000, e_hfp} - 11'd1;
          end else begin
            h_state_nx = H_SYNC;
            h_cnt_nx   = h_sync_len - 11'd1;
            line_end   = 1'b1;
          end
        end
        default: begin
          h_state_nx = H_SYNC;
          h_cnt_nx   = h_sync_len - 11'd1;
          line_end   = 1'b1;
        end
      endcase
    end
  end

  // Frame FSM: same scheme, counted in lines and advanced on each line end.
  always_comb begin
    v_cnt_cur  = sof_q ? (v_sync_len - 11'd1) : v_cnt;
    v_state_nx = v_state;
    v_cnt_nx   = v_cnt_cur;
    frame_end  = 1'b0;
    if (line_end) begin
      if (v_cnt_cur != 11'd0) begin
        v_cnt_nx = v_cnt_cur - 11'd1;
      end else begin
        case (v_state)
          V_SYNC: begin
            if (e_vbp != 8'd0) begin
              v_state_nx = V_BP;
              v_cnt_nx   = {3'b000, e_vbp} - 11'd1;
            end else begin
              v_state_nx = V_ACT;
              v_cnt_nx   = V_ACT_LAST;
            end
          end
          V_BP: begin
            v_state_nx = V_ACT;
            v_cnt_nx   = V_ACT_LAST;
          end
          V_ACT: begin
            if (e_vfp != 8'd0) begin
              v_state_nx = V_FP;
              v_cnt_nx   = {3'b000, e_vfp} - 11'd1;
            end else begin
              v_state_nx = V_SYNC;
              v_cnt_nx   = v_sync_len - 11'd1;
              frame_end  = 1'b1;
            end
          end
          default: begin
            v_state_nx = V_SYNC;
            v_cnt_nx   = v_sync_len - 11'd1;
            frame_end  = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      h_state <= H_SYNC;
      v_state <= V_SYNC;
      h_cnt   <= 11'd0;
      v_cnt   <= 11'd0;
      sof_q   <= 1'b1;
    end else begin
      h_state <= h_state_nx;
      v_state <= v_state_nx;
      h_cnt   <= h_cnt_nx;
      v_cnt   <= v_cnt_nx;
      sof_q   <= frame_end;
    end
  end

  // Shadow/live registers. The live copy takes the shadow's old value on the
  // apply cycle. A write in that same cycle stays pending for the next frame.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      sh_hfp   <= 8'(HOR_FP);   sh_hsync <= 8'(HOR_SYNC);  sh_hbp <= 8'(HOR_BP);
      sh_vfp   <= 8'(VERT_FP);  sh_vsync <= 8'(VERT_SYNC); sh_vbp <= 8'(VERT_BP);
      lv_hfp   <= 8'(HOR_FP);   lv_hsync <= 8'(HOR_SYNC);  lv_hbp <= 8'(HOR_BP);
      lv_vfp   <= 8'(VERT_FP);  lv_vsync <= 8'(VERT_SYNC); lv_vbp <= 8'(VERT_BP);
      pending_q <= 1'b0;
    end else begin
      if (cfg_we) begin
        if (!cfg_sel) begin
          sh_hfp <= cfg_fp; sh_hsync <= cfg_sync; sh_hbp <= cfg_bp;
        end else begin
          sh_vfp <= cfg_fp; sh_vsync <= cfg_sync; sh_vbp <= cfg_bp;
        end
      end
      if (sof_q) begin
        lv_hfp <= sh_hfp; lv_hsync <= sh_hsync; lv_hbp <= sh_hbp;
        lv_vfp <= sh_vfp; lv_vsync <= sh_vsync; lv_vbp <= sh_vbp;
        pending_q <= cfg_we;
      end else if (cfg_we) begin
        pending_q <= 1'b1;
      end
    end
  end

  // Stage 0: request and coordinates derived from the down-counters.
  logic act0;
  assign act0    = (h_state == H_ACT) && (v_state == V_ACT);
  assign pix_req = act0 && !rst;
  assign pix_x   = pix_req ? (H_ACT_LAST10 - h_cnt[9:0]) : 10'd0;
  assign pix_y   = pix_req ? (V_ACT_LAST10 - v_cnt[9:0]) : 10'd0;

  // Stage 1 carries timing alongside the fetch. Stage 2 registers the outputs.
  logic act_d1, hs_d1, vs_d1, fs_d1;

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      act_d1      <= 1'b0;
      hs_d1       <= 1'b1;
      vs_d1       <= 1'b1;
      fs_d1       <= 1'b0;
      r           <= 8'd0;
      g           <= 8'd0;
      b           <= 8'd0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      act_d1      <= act0;
      hs_d1       <= (h_state != H_SYNC);
      vs_d1       <= (v_state != V_SYNC);
      fs_d1       <= sof_q;
      r           <= act_d1 ? pix_r : 8'd0;
      g           <= act_d1 ? pix_g : 8'd0;
      b           <= act_d1 ? pix_b : 8'd0;
      hsync       <= hs_d1;
      vsync       <= vs_d1;
      frame_start <= fs_d1;
    end
  end

  assign cfg_pending = pending_q;
  assign h_state_dbg = h_state;
  assign v_state_dbg = v_state;

endmodule

// File: tb/tb_vdb_vga_timing_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vdb_vga_timing_ctrl
//   Bench for vdb_vga_timing_ctrl with a reduced raster (16x6 active). A frame
//   model pushes the expected {hsync, vsync, frame_start, r, g, b} for every
//   cycle into exp_q. A monitor pops one entry per cycle and compares it.
//   Directed checks cover reset values, cfg_pending, and pix_req/pix_x/pix_y.
// -----------------------------------------------------------------------------
module tb_vdb_vga_timing_ctrl;

  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 4;
  localparam int VA = 6,  VFP = 1, VSY = 2, VBP = 2;
  localparam logic [26:0] IDLE = {1'b1, 1'b1, 1'b0, 24'd0};

  // ---------------- clock / reset ----------------
  logic pixel_clk = 1'b0;
  logic rst = 1'b1;
  always #5 pixel_clk = ~pixel_clk;

  logic       cfg_we = 1'b0, cfg_sel = 1'b0;
  logic [7:0] cfg_fp = 8'd0, cfg_sync = 8'd0, cfg_bp = 8'd0;
  logic       cfg_pending, pix_req, hsync, vsync, frame_start;
  logic [9:0] pix_x, pix_y;
  logic [7:0] pix_r = 8'd0, pix_g = 8'd0, pix_b = 8'd0;
  logic [7:0] r, g, b;
  logic [1:0] h_state_dbg, v_state_dbg;

  vdb_vga_timing_ctrl #(
    .HOR_ACT(HA), .HOR_FP(HFP), .HOR_SYNC(HSY), .HOR_BP(HBP),
    .VERT_ACT(VA), .VERT_FP(VFP), .VERT_SYNC(VSY), .VERT_BP(VBP)
  ) dut (
    .pixel_clk(pixel_clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_fp(cfg_fp), .cfg_sync(cfg_sync), .cfg_bp(cfg_bp),
    .cfg_pending(cfg_pending), .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .r(r), .g(g), .b(b),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start),
    .h_state_dbg(h_state_dbg), .v_state_dbg(v_state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [26:0] exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  logic mon_on = 1'b0;
  int  cyc = 0;
  int  base = 0;

  // Model copies of the configuration.
  int  sh_hfp, sh_hsy, sh_hbp, sh_vfp, sh_vsy, sh_vbp;
  logic pending_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- pixel source (one-cycle latency) ----------------
  initial begin
    logic       req_s;
    logic [9:0] x_s, y_s;
    req_s = 1'b0; x_s = 10'd0; y_s = 10'd0;
    forever begin
      @(negedge pixel_clk);
      req_s = pix_req; x_s = pix_x; y_s = pix_y;
      @(posedge pixel_clk);
      #1;
      if (req_s === 1'b1) begin
        pix_r = x_s[7:0];
        pix_g = y_s[7:0];
        pix_b = x_s[7:0] ^ y_s[7:0] ^ 8'hA5;
      end else begin
        pix_r = 8'($urandom_range(0, 255));
        pix_g = 8'($urandom_range(0, 255));
        pix_b = 8'($urandom_range(0, 255));
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [26:0] e, a;
    forever begin
      @(negedge pixel_clk);
      if (mon_on) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL video_underflow at cycle %0d: got no expectation, required one", cyc);
        end else begin
          e = exp_q.pop_front();
          a = {hsync, vsync, frame_start, r, g, b};
          if (a !== e) begin
            n_errors++;
            $display("FAIL video at cycle %0d: got hs=%b vs=%b fs=%b rgb=%h_%h_%h required hs=%b vs=%b fs=%b rgb=%h_%h_%h",
                     cyc, a[26], a[25], a[24], a[23:16], a[15:8], a[7:0],
                     e[26], e[25], e[24], e[23:16], e[15:8], e[7:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks / model ----------------
  task automatic tick();
    @(posedge pixel_clk);
    #1;
    cyc++;
  endtask

  task automatic run_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push_frame(input int hf, hs, hb, vf, vs, vb, output int len);
    int hse, vse, htot, vtot, x, y;
    logic act;
    logic [7:0] xr, yr, br;
    hse  = (hs == 0) ? 1 : hs;
    vse  = (vs == 0) ? 1 : vs;
    htot = HA + hf + hse + hb;
    vtot = VA + vf + vse + vb;
    for (int l = 0; l < vtot; l++) begin
      for (int c = 0; c < htot; c++) begin
        act = (l >= vse + vb) && (l < vse + vb + VA) && (c >= hse + hb) && (c < hse + hb + HA);
        x = c - (hse + hb);
        y = l - (vse + vb);
        xr = x[7:0];
        yr = y[7:0];
        br = xr ^ yr ^ 8'hA5;
        exp_q.push_back({(c >= hse), (l >= vse), (l == 0 && c == 0),
                         act ? xr : 8'd0, act ? yr : 8'd0, act ? br : 8'd0});
      end
    end
    len = htot * vtot;
  endtask

  // Called in the first stage-0 cycle of a frame: shadows become live.
  task automatic start_frame();
    int len;
    pending_m = 1'b0;
    push_frame(sh_hfp, sh_hsy, sh_hbp, sh_vfp, sh_vsy, sh_vbp, len);
    base = base + len;
  endtask

  task automatic cfg_write(input logic sel, input int fp, sy, bp);
    cfg_sel = sel; cfg_fp = 8'(fp); cfg_sync = 8'(sy); cfg_bp = 8'(bp);
    cfg_we = 1'b1;
    if (!sel) begin sh_hfp = fp; sh_hsy = sy; sh_hbp = bp; end
    else      begin sh_vfp = fp; sh_vsy = sy; sh_vbp = bp; end
    pending_m = 1'b1;
    tick();
    cfg_we = 1'b0;
    chk("cfg_pending_after_write", cfg_pending, pending_m);
  endtask

  task automatic check_pending(input string name);
    chk(name, cfg_pending, pending_m);
  endtask

  task automatic check_req(input string name, input logic req, input int x, input int y);
    chk({name, "_req"}, pix_req, req);
    chk({name, "_x"}, pix_x, x);
    chk({name, "_y"}, pix_y, y);
  endtask

  // Holds rst for n+1 clock edges and checks the reset outputs along the way.
  task automatic do_reset(input int n);
    rst = 1'b1;
    cfg_we = 1'b0;
    mon_on = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_pix_req_immediate", pix_req, 1'b0);
    for (int i = 0; i < n; i++) begin
      @(posedge pixel_clk);
      @(negedge pixel_clk);
      chk("rst_hsync", hsync, 1'b1);
      chk("rst_vsync", vsync, 1'b1);
      chk("rst_frame_start", frame_start, 1'b0);
      chk("rst_rgb", {r, g, b}, 24'd0);
      chk("rst_pix_req", pix_req, 1'b0);
      chk("rst_cfg_pending", cfg_pending, 1'b0);
    end
    @(posedge pixel_clk);
    #1;
    rst = 1'b0;
    sh_hfp = HFP; sh_hsy = HSY; sh_hbp = HBP;
    sh_vfp = VFP; sh_vsy = VSY; sh_vbp = VBP;
    pending_m = 1'b0;
    cyc = 0;
    base = 0;
    exp_q.push_back(IDLE);
    exp_q.push_back(IDLE);
    mon_on = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    do_reset(2);

    // Frame 0 with reset timing (25-cycle lines, 11 lines). A mid-frame write
    // must not disturb this frame.
    start_frame();
    run_until(100);
    cfg_write(1'b0, 5, 4, 1);
    run_until(base);

    // Frame 1: 26-cycle lines, pending cleared by the apply.
    start_frame();
    tick();
    check_pending("pending_clear_f1");
    run_until(400);
    cfg_write(1'b0, 0, 3, 0);
    cfg_write(1'b1, 0, 0, 2);
    run_until(base);

    // Frame 2: no porches, 19-cycle lines, 9 lines, V_ACT straight to V_SYNC.
    start_frame();
    run_until(561 + 57 + 2);
    check_req("hsync_last", 1'b0, 0, 0);
    tick();
    check_req("first_pixel", 1'b1, 0, 0);
    run_until(561 + 57 + 18);
    check_req("last_pixel", 1'b1, 15, 0);
    tick();
    check_req("after_line", 1'b0, 0, 0);
    run_until(561 + 8 * 19 + 3);
    check_req("last_line", 1'b1, 0, 5);
    run_until(base);

    // Frame 3: a write on the apply cycle waits for the following frame.
    start_frame();
    cfg_write(1'b0, 2, 3, 4);
    run_until(base);

    // Frame 4: the apply-cycle write takes effect now.
    start_frame();
    tick();
    check_pending("pending_clear_f4");
    cfg_write(1'b1, 3, 3, 3);
    run_until(903 + 5 * 25 + 10);
    check_req("pre_reset_active", 1'b1, 3, 2);

    // Reset mid-active: restart from the parameter timing.
    do_reset(2);
    start_frame();
    tick();
    check_pending("pending_after_reset");
    run_until(base);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    mon_on = 1'b0;
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
